// File: rtl/fillq_mem_req_q.sv
// fillq_mem_req_q: memory-side request FIFO behind the fill queue.
// Optional feature macro MEMQ_BYPASS_EN: 0-cycle issue when the FIFO is empty.
package fillq_pkg;
    localparam int FLQ_NUM_ENTRIES = 8;
    localparam int FLQ_ID_W = $clog2(FLQ_NUM_ENTRIES);

    typedef struct packed {
        logic                valid;
        logic [FLQ_ID_W-1:0] id;
        logic [31:0]         addr;
    } t_mem_req;

    typedef struct packed {
        logic                valid;
        logic [FLQ_ID_W-1:0] id;
        logic [63:0]         data;
    } t_mem_rsp;
endpackage

module fillq_mem_req_q
    import fillq_pkg::*;
#(
    parameter int DEPTH    = FLQ_NUM_ENTRIES,
    parameter int MAX_OUTS = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  t_mem_req flq_mem_req_pkt,
    output t_mem_rsp flq_mem_rsp_pkt,
    output logic     mem_req_valid,
    output t_mem_req mem_req_pkt,
    input  logic     mem_req_ready,
    input  t_mem_rsp mem_rsp_pkt,
    output logic     memq_busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = 4;

    t_mem_req        fifo_q [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [OW-1:0]   outs_cnt;

    logic            fifo_vld;
    logic            outs_ok;
    logic            byp;
    logic            issue;
    logic            push;
    logic            pop;
    t_mem_req        head_pkt;

    // Issue selection: FIFO head, or the arriving request when bypassing.
    always_comb begin
        head_pkt = fifo_q[rd_ptr];
        fifo_vld = (count != '0);
        outs_ok  = (outs_cnt < OW'(MAX_OUTS));
`ifdef MEMQ_BYPASS_EN
        byp = !fifo_vld && outs_ok && flq_mem_req_pkt.valid;
`else
        byp = 1'b0;
`endif
        mem_req_valid     = (fifo_vld && outs_ok) || byp;
        mem_req_pkt       = byp ? flq_mem_req_pkt : head_pkt;
        mem_req_pkt.valid = mem_req_valid;
        issue = mem_req_valid && mem_req_ready;
        pop   = issue && !byp;
        push  = flq_mem_req_pkt.valid && !(byp && mem_req_ready);
        memq_busy = fifo_vld || (outs_cnt != '0);
    end

    // Payload storage; contents need no reset since count gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= flq_mem_req_pkt;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Outstanding request counter, saturating at zero on stray responses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            outs_cnt <= '0;
        end else if (issue && !mem_rsp_pkt.valid) begin
            outs_cnt <= outs_cnt + OW'(1);
        end else if (!issue && mem_rsp_pkt.valid && outs_cnt != '0) begin
            outs_cnt <= outs_cnt - OW'(1);
        end
    end

    // One-stage response register back to the fill queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flq_mem_rsp_pkt <= '0;
        end else begin
            flq_mem_rsp_pkt <= mem_rsp_pkt;
        end
    end

`ifndef SYNTHESIS
    // Flag pushes into a full FIFO and responses with nothing outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(push && !pop && count == CW'(DEPTH)))
                else $error("fillq_mem_req_q: push into full FIFO");
            assert (!(mem_rsp_pkt.valid && outs_cnt == '0))
                else $error("fillq_mem_req_q: response with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_fillq_mem_req_q.sv
// tb_fillq_mem_req_q: random stimulus against a queue-based reference model.
// A monitor on the falling edge pops expected values and compares.
module tb_fillq_mem_req_q;
    import fillq_pkg::*;

    localparam int DEPTH    = FLQ_NUM_ENTRIES;
    localparam int MAX_OUTS = 4;

    logic     clk = 1'b0;
    logic     reset = 1'b0;
    t_mem_req req;
    t_mem_rsp mrsp;
    t_mem_rsp frsp;
    logic     mvalid;
    t_mem_req mpkt;
    logic     mready;
    logic     busy;

    always #5 clk = ~clk;

    fillq_mem_req_q #(.DEPTH(DEPTH), .MAX_OUTS(MAX_OUTS)) dut (
        .clk             (clk),
        .reset           (reset),
        .flq_mem_req_pkt (req),
        .flq_mem_rsp_pkt (frsp),
        .mem_req_valid   (mvalid),
        .mem_req_pkt     (mpkt),
        .mem_req_ready   (mready),
        .mem_rsp_pkt     (mrsp),
        .memq_busy       (busy)
    );

    typedef struct {
        bit          valid;
        bit          busy;
        bit          rvalid;
        int          rid;
        logic [63:0] rdata;
    } st_t;

    st_t      st_q[$];
    t_mem_req iss_q[$];
    int       n_chk = 0;
    int       n_fail = 0;

    t_mem_req mq[$];
    int       inflight[$];
    int       outs;
    bit       id_busy[FLQ_NUM_ENTRIES];
    t_mem_rsp prev_rsp;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic step(bit rst, bit rq, logic [31:0] addr, int id, bit rdy, bit rs);
        st_t      st;
        bit       ev;
        bit       bp;
        int       k;
        int       free[$];
        t_mem_req nr;
        t_mem_req iss;
        t_mem_rsp r;
        @(posedge clk);
        #1;
        nr = '0;
        r  = '0;
        bp = 1'b0;
        if (rst) begin
            reset  = 1'b0;
            req    = '0;
            mrsp   = '0;
            mready = rdy;
            mq.delete();
            inflight.delete();
            iss_q.delete();
            outs = 0;
            foreach (id_busy[i]) id_busy[i] = 1'b0;
            prev_rsp = '0;
            return;
        end
        reset = 1'b1;
        if (rq && id < 0) begin
            for (int i = 0; i < FLQ_NUM_ENTRIES; i++)
                if (!id_busy[i]) free.push_back(i);
            if (free.size() == 0) rq = 1'b0;
            else id = free[$urandom_range(free.size() - 1)];
        end
        if (rq) begin
            nr.valid = 1'b1;
            nr.id    = FLQ_ID_W'(id);
            nr.addr  = addr;
        end
        if (rs && inflight.size() > 0) begin
            k = $urandom_range(inflight.size() - 1);
            r.valid = 1'b1;
            r.id    = FLQ_ID_W'(inflight[k]);
            r.data  = {$urandom, $urandom};
            inflight.delete(k);
            id_busy[r.id] = 1'b0;
        end
        req    = nr;
        mrsp   = r;
        mready = rdy;
        st.busy = (mq.size() != 0) || (outs != 0);
        ev = (mq.size() != 0) && (outs < MAX_OUTS);
`ifdef MEMQ_BYPASS_EN
        bp = (mq.size() == 0) && (outs < MAX_OUTS) && nr.valid;
        ev = ev || bp;
`endif
        st.valid  = ev;
        st.rvalid = prev_rsp.valid;
        st.rid    = int'(prev_rsp.id);
        st.rdata  = prev_rsp.data;
        st_q.push_back(st);
        if (ev && rdy) begin
            if (bp) iss = nr;
            else iss = mq.pop_front();
            iss_q.push_back(iss);
            inflight.push_back(int'(iss.id));
            outs++;
        end
        if (nr.valid && !(bp && rdy)) mq.push_back(nr);
        if (nr.valid) id_busy[nr.id] = 1'b1;
        if (r.valid) outs--;
        prev_rsp = r;
    endtask

    always @(negedge clk) begin : monitor
        st_t      s;
        t_mem_req e;
        if (reset) begin
            if (st_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL state_q: got empty expected entry at %0t", $time);
            end else begin
                s = st_q.pop_front();
                check("mem_req_valid", 64'(mvalid), 64'(s.valid));
                check("memq_busy", 64'(busy), 64'(s.busy));
                check("rsp_valid", 64'(frsp.valid), 64'(s.rvalid));
                if (s.rvalid) begin
                    check("rsp_id", 64'(frsp.id), 64'(s.rid));
                    check("rsp_data", frsp.data, s.rdata);
                end
                if (mvalid && mready) begin
                    if (iss_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL issue: got id %0h expected no issue at %0t",
                                 mpkt.id, $time);
                    end else begin
                        e = iss_q.pop_front();
                        check("issue_id", 64'(mpkt.id), 64'(e.id));
                        check("issue_addr", 64'(mpkt.addr), 64'(e.addr));
                    end
                end
            end
        end
    end

    initial begin
        int pq, pr, ps;
        req      = '0;
        mrsp     = '0;
        mready   = 1'b0;
        prev_rsp = '0;
        outs     = 0;
        step(1, 0, 0, -1, 0, 0);
        step(1, 0, 0, -1, 0, 0);

        // single request, response four cycles after issue
        step(0, 1, 32'h1000, 2, 1, 0);
        repeat (4) step(0, 0, 0, -1, 1, 0);
        step(0, 0, 0, -1, 1, 1);
        repeat (3) step(0, 0, 0, -1, 1, 0);

        // burst of four under a 10-cycle stall
        for (int i = 0; i < 4; i++) step(0, 1, $urandom, i, 0, 0);
        repeat (10) step(0, 0, 0, -1, 0, 0);
        repeat (6) step(0, 0, 0, -1, 1, 0);
        repeat (6) step(0, 0, 0, -1, 1, 1);

        // outstanding limit with six requests
        for (int i = 0; i < 6; i++) step(0, 1, $urandom, -1, 1, 0);
        repeat (4) step(0, 0, 0, -1, 1, 0);
        step(0, 0, 0, -1, 1, 1);
        repeat (3) step(0, 0, 0, -1, 1, 0);
        repeat (10) step(0, 0, 0, -1, 1, 1);

        // random traffic in phases of varying pressure
        for (int p = 0; p < 15; p++) begin
            pq = $urandom_range(90, 10);
            pr = $urandom_range(95, 5);
            ps = $urandom_range(80, 5);
            repeat (100)
                step(0, $urandom_range(99) < pq, $urandom, -1,
                     $urandom_range(99) < pr, $urandom_range(99) < ps);
        end

        // reset with requests queued and outstanding
        repeat (20) step(0, 0, 0, -1, 1, 1);
        step(0, 1, $urandom, -1, 1, 0);
        step(0, 1, $urandom, -1, 1, 0);
        repeat (3) step(0, 1, $urandom, -1, 0, 0);
        step(1, 0, 0, -1, 0, 0);
        step(0, 1, 32'h2000, 5, 1, 0);
        repeat (3) step(0, 0, 0, -1, 1, 0);
        repeat (200)
            step(0, $urandom_range(99) < 50, $urandom, -1,
                 $urandom_range(99) < 70, $urandom_range(99) < 40);

        repeat (30) step(0, 0, 0, -1, 1, 1);
        repeat (2) step(0, 0, 0, -1, 1, 0);
        @(negedge clk);
        #1;
        check("issue_q_left", 64'(iss_q.size()), 64'd0);
        check("state_q_left", 64'(st_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
